// File: rtl/maxpool2x2_scheduler.sv
// 2x2 / stride-2 max-pooling sequencer: walks the window grid of one conv
// result plane, reduces each returned window to its signed maximum and
// writes the results sequentially to the pooled-output memory.
module maxpool2x2_scheduler #(
    parameter int unsigned n_c                  = 26,
    parameter int unsigned n_r                  = 26,
    parameter int unsigned dataWidthImg         = 16,
    parameter int unsigned addressWidthRstlConv = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   hold,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   ren,
    output logic        [addressWidthRstlConv-1:0] radd1,
    output logic        [addressWidthRstlConv-1:0] radd2,
    input  logic signed [dataWidthImg-1:0]         rdata0,
    input  logic signed [dataWidthImg-1:0]         rdata1,
    input  logic signed [dataWidthImg-1:0]         rdata2,
    input  logic signed [dataWidthImg-1:0]         rdata3,
    output logic                                   wen,
    output logic        [addressWidthRstlConv-1:0] wadd,
    output logic signed [dataWidthImg-1:0]         data_out
);

    localparam int unsigned AW = addressWidthRstlConv;
    localparam int unsigned DW = dataWidthImg;
    localparam int unsigned PC = n_c / 2;
    localparam int unsigned PR = n_r / 2;
    localparam logic [AW-1:0] PC_LAST = AW'(PC - 1);
    localparam logic [AW-1:0] PR_LAST = AW'(PR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] pr_q, pr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] radd1_d, radd2_d;
    logic          ren_d;
    logic          busy_d;
    logic          done_d;
    logic          clear_wadd_c;
    logic          v1_q;

    logic signed [DW-1:0] max01_c, max23_c, max_c;

    // Two-level signed compare tree over the window returned this cycle
    always_comb begin
        max01_c = (rdata0 > rdata1) ? rdata0 : rdata1;
        max23_c = (rdata2 > rdata3) ? rdata2 : rdata3;
        max_c   = (max01_c > max23_c) ? max01_c : max23_c;
    end

    // State, window counters and registered read-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pr_q    <= '0;
            pc_q    <= '0;
            ren     <= 1'b0;
            radd1   <= '0;
            radd2   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            ren     <= ren_d;
            radd1   <= radd1_d;
            radd2   <= radd2_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, window walk and handshake outputs
    always_comb begin
        state_d      = state_q;
        pr_d         = pr_q;
        pc_d         = pc_q;
        ren_d        = 1'b0;
        radd1_d      = radd1;
        radd2_d      = radd2;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        clear_wadd_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SCAN;
                    pr_d         = '0;
                    pc_d         = '0;
                    clear_wadd_c = 1'b1;
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                if (!hold) begin
                    ren_d   = 1'b1;
                    radd1_d = AW'(pr_q << 1);
                    radd2_d = AW'(pc_q << 1);
                    if (pc_q == PC_LAST) begin
                        pc_d = '0;
                        if (pr_q == PR_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            pr_d = pr_q + AW'(1);
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                // Once the final read has retired only the last write remains
                busy_d = 1'b1;
                if (!ren) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-return pipeline: stage-1 valid, then max result and write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            wen      <= 1'b0;
            wadd     <= '0;
            data_out <= '0;
        end else begin
            v1_q <= ren;
            wen  <= v1_q;
            if (v1_q) begin
                data_out <= max_c;
            end
            if (clear_wadd_c) begin
                wadd <= '0;
            end else if (wen) begin
                wadd <= wadd + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_scheduler.sv
// Directed bench for maxpool2x2_scheduler: a 26x26 ramp-plane instance and a
// 5x5 instance carrying signed corner-case windows, each fed by a small
// memory model that returns the four window pixels one cycle after ren.
module tb_maxpool2x2_scheduler;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, hold;
    logic busy, done, ren, wen;
    logic [AW-1:0] radd1, radd2, wadd;
    logic signed [DW-1:0] rdata0, rdata1, rdata2, rdata3, data_out;

    logic start5;
    logic busy5, done5, ren5, wen5;
    logic [AW-1:0] radd1_5, radd2_5, wadd5;
    logic signed [DW-1:0] rd5_0, rd5_1, rd5_2, rd5_3, data5;

    int total = 0;
    int bad   = 0;

    maxpool2x2_scheduler #(
        .n_c(26), .n_r(26), .dataWidthImg(DW), .addressWidthRstlConv(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .ren(ren), .radd1(radd1), .radd2(radd2),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .wen(wen), .wadd(wadd), .data_out(data_out)
    );

    maxpool2x2_scheduler #(
        .n_c(5), .n_r(5), .dataWidthImg(DW), .addressWidthRstlConv(AW)
    ) dut5 (
        .clk(clk), .rst(rst), .start(start5), .hold(1'b0),
        .busy(busy5), .done(done5), .ren(ren5), .radd1(radd1_5), .radd2(radd2_5),
        .rdata0(rd5_0), .rdata1(rd5_1), .rdata2(rd5_2), .rdata3(rd5_3),
        .wen(wen5), .wadd(wadd5), .data_out(data5)
    );

    function automatic logic signed [DW-1:0] ramp26(input int r, input int c);
        return DW'(r * 26 + c);
    endfunction

    // 5x5 plane: windows (0,0) and (0,2) hold signed corner cases, rest is a ramp
    function automatic logic signed [DW-1:0] pix5(input int r, input int c);
        if (r < 2 && c < 2) begin
            if (r == 0) return (c == 0) ? -16'sd5 : -16'sd3;
            else        return (c == 0) ? -16'sd128 : -16'sd7;
        end else if (r < 2 && c < 4) begin
            if (r == 0) return (c == 2) ? -16'sd1 : 16'sd0;
            else        return (c == 2) ? 16'sh8000 : -16'sd2;
        end
        return DW'(r * 5 + c);
    endfunction

    // Result-memory models: pixels valid the cycle after ren
    always @(posedge clk) begin
        if (ren) begin
            rdata0 <= ramp26(int'(radd1),     int'(radd2));
            rdata1 <= ramp26(int'(radd1),     int'(radd2) + 1);
            rdata2 <= ramp26(int'(radd1) + 1, int'(radd2));
            rdata3 <= ramp26(int'(radd1) + 1, int'(radd2) + 1);
        end
        if (ren5) begin
            rd5_0 <= pix5(int'(radd1_5),     int'(radd2_5));
            rd5_1 <= pix5(int'(radd1_5),     int'(radd2_5) + 1);
            rd5_2 <= pix5(int'(radd1_5) + 1, int'(radd2_5));
            rd5_3 <= pix5(int'(radd1_5) + 1, int'(radd2_5) + 1);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 26x26 pass. Cycle t is the interval after edge t; edge 0 samples start.
    // ren is expected to be absent in cycles hf..ht; a second start is offered
    // at edge s2; a reset is applied mid-cycle rst_at if rst_at >= 0.
    task automatic run_ramp(input int hf, input int ht, input int rst_at,
                            input int s2, input int exp_done);
        int  w = 0;
        int  nw = 0;
        bit  exp_ren;
        for (int t = 0; t <= exp_done + 3; t++) begin
            start = (t == 0) || (t == s2);
            hold  = (t >= hf) && (t <= ht);
            step();
            start = 1'b0;
            hold  = 1'b0;
            chk("busy", busy, (t >= 1) && (t <= exp_done));
            exp_ren = (t >= 1) && (w < 169) && !((t >= hf) && (t <= ht));
            chk("ren", ren, exp_ren);
            if (ren && exp_ren) begin
                chk("radd1", radd1, 2 * (w / 13));
                chk("radd2", radd2, 2 * (w % 13));
                w++;
            end
            if (wen) begin
                chk("wadd", wadd, nw);
                chk("data_out", data_out, (2 * (nw / 13) + 1) * 26 + 2 * (nw % 13) + 1);
                nw++;
            end
            if (t == rst_at) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rst_ctl", {busy, done, ren, wen}, 0);
                chk("rst_addr", {radd1, radd2, wadd}, 0);
                chk("rst_data", data_out, 0);
                repeat (3) step();
                rst = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    step();
                    chk("post_rst_quiet", {busy, done, ren, wen}, 0);
                end
                return;
            end
            if (done) begin
                chk("done_cycle", t, exp_done);
                chk("write_count", nw, 169);
                chk("read_count", w, 169);
                return;
            end
        end
        chk("done_seen", 0, 1);
    endtask

    // 5x5 plane: four windows, last row/column never read, done in cycle 7
    task automatic run5();
        int exp5[4];
        int w = 0;
        int nw = 0;
        exp5 = '{-3, 0, 16, 18};
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        chk("busy5_c0", busy5, 0);
        for (int t = 1; t <= 10; t++) begin
            step();
            chk("ren5", ren5, t <= 4);
            if (ren5) begin
                chk("radd1_5", radd1_5, 2 * (w / 2));
                chk("radd2_5", radd2_5, 2 * (w % 2));
                w++;
            end
            if (wen5) begin
                chk("wadd5", wadd5, nw);
                if (nw < 4) chk("data5", data5, exp5[nw]);
                nw++;
            end
            if (done5) begin
                chk("done5_cycle", t, 7);
                chk("write5_count", nw, 4);
                return;
            end
        end
        chk("done5_seen", 0, 1);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        hold   = 1'b0;
        start5 = 1'b0;
        repeat (2) step();
        chk("reset_ctl", {busy, done, ren, wen}, 0);
        chk("reset_addr", {radd1, radd2, wadd}, 0);
        chk("reset_data", data_out, 0);
        rst = 1'b0;
        step();

        // plain ramp pass
        run_ramp(1000, 0, -1, -1, 172);
        // back-to-back start at edge 173, with an extra start at edge 20 ignored
        run_ramp(1000, 0, -1, 20, 172);
        // hold suppresses reads in cycles 5..9
        run_ramp(5, 9, -1, -1, 177);
        // reset aborts a pass at cycle 50, then a fresh full pass
        step();
        run_ramp(1000, 0, 50, -1, 172);
        run_ramp(1000, 0, -1, -1, 172);
        // small plane with signed windows
        step();
        run5();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_scheduler.md
Name: maxpool2x2_scheduler

Overview:
- Sequences the 2x2/stride-2 max-pooling pass over one conv-result plane held in the 4-port-read result memory.
- Issues one window read per cycle as a top-left (row, col) pair; the memory forms the four addresses p, p+1, p+n_c and p+n_c+1.
- Takes the signed maximum of the four returned pixels and writes it sequentially to the pooled-output memory.
- Sits between the conv-result store and the next layer's input buffer; the top-level FSM starts it through a start/busy/done handshake.

Parameters:
- n_c, 26: columns of the input plane.
- n_r, 26: rows of the input plane.
- dataWidthImg, 16: width of each pixel read back from the result memory.
- addressWidthRstlConv, 10: width of radd1, radd2 and wadd.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- hold  in  1  stalls issuing of new window reads.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- ren  out  1  read enable to the result memory.
- radd1  out  addressWidthRstlConv  window top-left row (always even).
- radd2  out  addressWidthRstlConv  window top-left column (always even).
- rdata0..rdata3  in  dataWidthImg each, signed  pixels at p, p+1, p+n_c, p+n_c+1; valid the cycle after ren.
- wen  out  1  write enable to the pooled memory.
- wadd  out  addressWidthRstlConv  pooled write address.
- data_out  out  dataWidthImg, signed  pooled value.

Behaviour:
- Sizes: PC = n_c/2 and PR = n_r/2 (floor division). An odd last row or column is dropped. P = PR*PC; defaults give PC = 13, PR = 13, P = 169.
- Reset (async, any state): every output goes to 0, the FSM goes to IDLE, counters and the pipeline valid bits clear. A reset mid-pass aborts it; no wen or done follows.
- States:
  - IDLE: waits for start.
  - SCAN: issues window reads.
  - DRAIN: empties the pipeline.
  - FIN: pulses done.
- IDLE -> SCAN on start. Counters pr = pc = 0, wadd = 0.
- SCAN, each cycle with hold = 0:
  - ren = 1, radd1 = 2*pr, radd2 = 2*pc.
  - pc increments; at PC-1 it wraps to 0 and pr increments.
  - Issuing the window (PR-1, PC-1) moves the FSM to DRAIN.
- SCAN with hold = 1: ren = 0, counters frozen, radd1/radd2 hold their last values. Windows already issued still complete.
- Pipeline:
  - ren in cycle t -> rdata valid in t+1.
  - In t+1, data_out <= signed max(rdata0..3) and wen <= 1, both visible in t+2.
  - wadd increments after each write: 0, 1, ..., P-1.
  - wen is 0 whenever no valid stage-1 data exists.
- DRAIN -> FIN once the last wen has occurred. FIN: done = 1 for one cycle, then IDLE.
- busy = 1 from the cycle after start is sampled through the done cycle inclusive.
- A start while busy is ignored. A start and reset together: reset wins.
- Max: two-level signed compare tree, full dataWidthImg. No saturation needed; equal values yield that value.
- Default timing, no hold (cycle 0 = edge sampling start):
  - ren in cycles 1..169;
  - wen in cycles 3..171;
  - done in cycle 172.

Test Plan:
- Ramp plane, pixel value = row*26 + col, no hold:
  - 169 writes, wadd 0..168;
  - data_out[k] = (2*(k/13)+1)*26 + 2*(k%13) + 1, so data_out[0] = 27 and data_out[168] = 675;
  - done in cycle 172 only.
- Signed data: window {-5, -3, -128, -7} -> data_out = -3. Window {-1, 0, -32768, -2} -> 0.
- hold held high for cycles 5..9:
  - no ren in those cycles;
  - ren resumes with radd1 = 0, radd2 = 8;
  - write sequence identical to the ramp case, done 5 cycles later (cycle 177).
- Reset asserted at cycle 50:
  - all outputs 0 asynchronously;
  - no further wen or done;
  - a new start yields a full, correct 169-write pass.
- Start pulsed at cycles 0 and 20: only one pass, exactly 169 writes. A start in cycle 173 begins a second pass.
- n_c = n_r = 5:
  - 4 windows at (0,0), (0,2), (2,0), (2,2);
  - the last row and column are never read;
  - done in cycle 7.
